// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor sequencer: one full-subtractor slice, LSB first
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE_S
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic bit_d;
  logic borrow_nxt;

  // One-bit full-subtractor slice on the current LSBs and the held borrow
  always_comb begin
    bit_d      = op_a[0] ^ op_b[0] ^ borrow;
    borrow_nxt = (~op_a[0] & (op_b[0] | borrow)) | (op_b[0] & borrow);
  end

  // Zero flag looks only at the registered difference
  assign zero = (D == '0);

  // Sequencer: capture on start, one bit per cycle, single-cycle done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            op_a   <= A;
            op_b   <= B;
            borrow <= Bin;
            cnt    <= '0;
            D      <= '0;
            Bout   <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          D      <= {bit_d, D[WIDTH-1:1]};
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          borrow <= borrow_nxt;
          if (cnt == LAST) begin
            // Counter parks at zero instead of wrapping past the last bit
            cnt   <= '0;
            Bout  <= borrow_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_S;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Bin(bin),
    .busy(busy), .done(done), .D(d), .Bout(bout), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: edges elapsed since the last accepted start, and the full
  // (WIDTH+1)-bit result of that operation
  int       since = -1;
  logic [W:0] res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since <= -1;
      res   <= '0;
    end else if ((since < 0 || since > W) && start) begin
      since <= 0;
      res   <= {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    end else if (since >= 0 && since <= W) begin
      since <= since + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
    end else begin
      chk("m_busy", 32'(busy), 32'(since >= 0 && since < W));
      chk("m_done", 32'(done), 32'(since == W));
      if (since < 0 || since >= W) begin
        chk("m_d", 32'(d), 32'(res[W-1:0]));
        chk("m_bout", 32'(bout), 32'(res[W]));
        chk("m_zero", 32'(zero), 32'(res[W-1:0] == '0));
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic ez, input string name);
    int k;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_lat"}, 32'(k), 32'(W + 1));
    chk({name, "_d"}, 32'(d), 32'(ed));
    chk({name, "_bout"}, 32'(bout), 32'(eb));
    chk({name, "_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    int ndone;
    int prev;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    logic rbin;

    repeat (2) @(negedge clk);
    chk("reset_d", 32'(d), 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    fork
      forever begin
        @(negedge clk);
        model_cmp();
      end
    join_none
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "t5a3c");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "t0001");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "tffff1");
    run_op(8'h37, 8'h37, 1'b0, 8'h00, 1'b0, 1'b1, "t3737");

    // Start while busy must be ignored and operands must stay captured
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h33; b = 8'h44;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("busy_start_d", 32'(d), 32'h7F);
        chk("busy_start_bout", 32'(bout), 32'd0);
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);

    // Start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    ndone = 0;
    prev = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        chk("hold_d", 32'(d), 32'hF0);
        chk("hold_bout", 32'(bout), 32'd1);
        if (ndone > 0) chk("hold_period", 32'(k - prev), 32'(W + 2));
        prev = k;
        ndone++;
      end
    end
    start = 1'b0;
    chk("hold_ndone", 32'(ndone), 32'd4);
    repeat (2) @(negedge clk);

    // Reset mid-operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, "tpost_rst");

    // Random sweep against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      e = {1'b0, ra} - {1'b0, rb} - (W+1)'(rbin);
      run_op(ra, rb, rbin, e[W-1:0], e[W], e[W-1:0] == '0, "rand");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
